// File: rtl/regbank_pkg.sv
// Shared sizing and FSM encoding for the two-requester register bank arbiter.
package regbank_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned NREGS     = 2 ** ADDR_W;
  localparam int unsigned MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage : regbank_pkg

// File: rtl/regbank_16x32.sv
// Register storage: one synchronous write port, one registered read port, async clear.
module regbank_16x32 #(
  parameter int unsigned DATA_W = regbank_pkg::DATA_W,
  parameter int unsigned ADDR_W = regbank_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] bank [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        bank[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        bank[waddr] <= wdata;
      end
      if (re) begin
        rdata <= bank[raddr];
      end
    end
  end

endmodule : regbank_16x32

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter with bounded locked bursts in front of a register bank.
module regbank_arbiter #(
  parameter int unsigned DATA_W    = regbank_pkg::DATA_W,
  parameter int unsigned ADDR_W    = regbank_pkg::ADDR_W,
  parameter int unsigned MAX_BURST = regbank_pkg::MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  import regbank_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic [1:0]        accept;
  logic              acc_idx;
  logic              own_idx;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rr_ptr    <= 1'b1;
      rsp_valid <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      rsp_valid <= accept & ~req_we;
      if (|accept) begin
        rr_ptr <= acc_idx;
      end
    end
  end

  // Grant selection and ownership/burst tracking.
  always_comb begin
    req_ready     = 2'b00;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    own_idx       = (state == OWN1);

    unique case (state)
      IDLE: begin
        if (req_valid == 2'b11) begin
          req_ready = rr_ptr ? 2'b01 : 2'b10;
        end else begin
          req_ready = req_valid;
        end
      end
      OWN0:    req_ready = {1'b0, req_valid[0]};
      OWN1:    req_ready = {req_valid[1], 1'b0};
      default: req_ready = 2'b00;
    endcase
    if (rst) begin
      req_ready = 2'b00;
    end

    accept  = req_valid & req_ready;
    acc_idx = accept[1];

    unique case (state)
      IDLE: begin
        if (|accept && req_lock[acc_idx] && (MAX_BURST > 1)) begin
          state_nxt     = acc_idx ? OWN1 : OWN0;
          burst_cnt_nxt = CNT_W'(1);
        end
      end
      OWN0, OWN1: begin
        if (!req_valid[own_idx]) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end else if (|accept) begin
          // Forced release once the burst reaches its cap, regardless of lock.
          if (!req_lock[own_idx] || (burst_cnt + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  assign acc_addr  = acc_idx ? req_addr1 : req_addr0;
  assign acc_wdata = acc_idx ? req_wdata1 : req_wdata0;

  regbank_16x32 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (|(accept & req_we)),
    .waddr (acc_addr),
    .wdata (acc_wdata),
    .re    (|(accept & ~req_we)),
    .raddr (acc_addr),
    .rdata (rsp_rdata)
  );

endmodule : regbank_arbiter

// File: tb/tb_regbank_arbiter.sv
// Directed self-checking bench for regbank_arbiter.
module tb_regbank_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [1:0]        req_lock;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  regbank_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs and let the combinational grant settle before sampling it.
  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [3:0] a0, input logic [31:0] d0,
                       input logic [3:0] a1, input logic [31:0] d1);
    req_valid  = v;
    req_we     = we;
    req_lock   = lk;
    req_addr0  = a0;
    req_wdata0 = d0;
    req_addr1  = a1;
    req_wdata1 = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_gnt [5];
  logic [31:0] exp_dat [4];

  initial begin
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Write then read back address 5 from requester 0.
    drive(2'b01, 2'b01, 2'b00, 4'd5, 32'hDEADBEEF, 4'd0, 32'h0);
    check("wr5_ready", 32'(req_ready), 32'h1);
    tick();
    check("wr5_no_rsp", 32'(rsp_valid), 32'h0);
    drive(2'b01, 2'b00, 2'b00, 4'd5, 32'h0, 4'd0, 32'h0);
    check("rd5_ready", 32'(req_ready), 32'h1);
    tick();
    check("rd5_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd5_rdata", rsp_rdata, 32'hDEADBEEF);

    // Write by 0 to addr 15, read by 1 on the very next cycle.
    drive(2'b01, 2'b01, 2'b00, 4'd15, 32'h1234, 4'd0, 32'h0);
    check("wr15_ready", 32'(req_ready), 32'h1);
    tick();
    drive(2'b10, 2'b00, 2'b00, 4'd0, 32'h0, 4'd15, 32'h0);
    check("rd15_ready", 32'(req_ready), 32'h2);
    tick();
    check("rd15_rsp_valid", 32'(rsp_valid), 32'h2);
    check("rd15_rdata", rsp_rdata, 32'h1234);

    // Continuous tie without lock alternates starting with requester 0.
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    exp_dat = '{32'hDEADBEEF, 32'h1234, 32'hDEADBEEF, 32'h1234};
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 2'b00, 4'd5, 32'h0, 4'd15, 32'h0);
      check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(exp_gnt[i]));
      tick();
      check($sformatf("rr_rsp_valid_%0d", i), 32'(rsp_valid), 32'(exp_gnt[i]));
      check($sformatf("rr_rdata_%0d", i), rsp_rdata, exp_dat[i]);
    end

    // Give requester 0 a turn so requester 1 wins the next tie, then lock 1.
    drive(2'b01, 2'b00, 2'b00, 4'd5, 32'h0, 4'd15, 32'h0);
    check("pre_lock_ready", 32'(req_ready), 32'h1);
    tick();
    exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 2'b00, 2'b10, 4'd5, 32'h0, 4'd15, 32'h0);
      check($sformatf("burst_ready_%0d", i), 32'(req_ready), 32'(exp_gnt[i]));
      tick();
    end

    // Owner 0 locks, excludes 1, then drops valid and releases to 1.
    drive(2'b01, 2'b00, 2'b01, 4'd5, 32'h0, 4'd15, 32'h0);
    check("own0_first_ready", 32'(req_ready), 32'h1);
    tick();
    drive(2'b11, 2'b00, 2'b01, 4'd5, 32'h0, 4'd15, 32'h0);
    check("own0_excl_ready", 32'(req_ready), 32'h1);
    tick();
    drive(2'b10, 2'b00, 2'b00, 4'd5, 32'h0, 4'd15, 32'h0);
    check("own0_drop_ready", 32'(req_ready), 32'h0);
    tick();
    drive(2'b10, 2'b00, 2'b00, 4'd5, 32'h0, 4'd15, 32'h0);
    check("after_drop_ready", 32'(req_ready), 32'h2);
    tick();

    // Reset right after a locked read accept.
    drive(2'b01, 2'b00, 2'b01, 4'd5, 32'h0, 4'd15, 32'h0);
    check("pre_rst_ready", 32'(req_ready), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_ready", 32'(req_ready), 32'h0);
    check("midrst_rdata", rsp_rdata, 32'h0);
    drive(2'b00, 2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_rsp_valid", 32'(rsp_valid), 32'h0);

    drive(2'b11, 2'b00, 2'b00, 4'd5, 32'h0, 4'd15, 32'h0);
    check("postrst_tie_ready", 32'(req_ready), 32'h1);
    tick();
    check("postrst_rd5_valid", 32'(rsp_valid), 32'h1);
    check("postrst_rd5_rdata", rsp_rdata, 32'h0);
    drive(2'b10, 2'b00, 2'b00, 4'd0, 32'h0, 4'd15, 32'h0);
    check("postrst_rd15_ready", 32'(req_ready), 32'h2);
    tick();
    check("postrst_rd15_valid", 32'(rsp_valid), 32'h2);
    check("postrst_rd15_rdata", rsp_rdata, 32'h0);
    drive(2'b00, 2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    check("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regbank_arbiter

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 Parameter MAX_BURST, default 4, max transactions per locked ownership.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  2  per-requester transaction request.
REQ-008 req_we  in  2  per-requester write enable (1 = write, 0 = read).
REQ-009 req_lock  in  2  per-requester request to keep ownership after this transaction.
REQ-010 req_addr0, req_addr1  in  ADDR_W each  register index.
REQ-011 req_wdata0, req_wdata1  in  DATA_W each  write data.
REQ-012 req_ready  out  2  grant; a transaction is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-013 rsp_valid  out  2  read-response strobe, one cycle.
REQ-014 rsp_rdata  out  DATA_W  read data, valid only while either bit of rsp_valid is 1.

Function
REQ-015 At most one req_ready bit SHALL be 1 per cycle.
REQ-016 req_ready SHALL be combinational from state, rr_ptr and req_valid, and SHALL NOT depend on req_we, req_addr or req_wdata.
REQ-017 The FSM SHALL have the states IDLE, OWN0 and OWN1.
REQ-018 In IDLE with one valid requester, that requester SHALL be granted.
REQ-019 In IDLE with both valid, the requester whose index differs from rr_ptr SHALL be granted.
REQ-020 rr_ptr SHALL update to the granted index on every accept.
REQ-021 In OWNi only requester i SHALL be grantable, and req_ready[1-i] SHALL be 0.
REQ-022 An accepted write SHALL update bank[addr] with wdata at that clock edge.
REQ-023 An accepted read SHALL raise rsp_valid[i] exactly one cycle later, with rsp_rdata = bank[addr].
REQ-024 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-025 burst_cnt SHALL count accepts within an ownership, including the first accept.
REQ-026 From IDLE, an accept with req_lock=1 SHALL go to OWNi with burst_cnt=1.
REQ-027 OWNi SHALL return to IDLE on an accept with req_lock=0.
REQ-028 OWNi SHALL return to IDLE on an accept that makes burst_cnt reach MAX_BURST, regardless of req_lock (forced release).
REQ-029 OWNi SHALL return to IDLE in any cycle where req_valid[i]=0.
REQ-030 On any return to IDLE, burst_cnt SHALL clear to 0.
REQ-031 After a forced release with both requesters valid, the other requester SHALL win the next IDLE arbitration.
REQ-032 With MAX_BURST=1, req_lock SHALL have no effect and the FSM SHALL never leave IDLE.

Reset
REQ-033 On reset the state SHALL be IDLE, rr_ptr=1 (requester 0 wins the first tie), burst_cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, and all bank registers 0.
REQ-034 A reset asserted mid-operation SHALL immediately drop any pending response and any ownership; no rsp_valid SHALL appear after reset release for pre-reset reads.
REQ-035 req_ready SHALL be 0 while rst=1.

Structure
REQ-036 Package regbank_pkg SHALL hold DATA_W, ADDR_W, NREGS=2**ADDR_W, MAX_BURST and the FSM state encoding.
REQ-037 The storage SHALL be the sub-module regbank_16x32: one synchronous write port, one registered read port, and async reset clear.
REQ-038 Arbitration, FSM and burst counter SHALL reside in regbank_arbiter; no other sub-modules.

Verification
REQ-039 Reset then req_valid=01, we=1, addr=5, wdata=0xDEADBEEF; then read addr 5 -> rsp_valid=01 one cycle after accept, rsp_rdata=0xDEADBEEF.
REQ-040 Both requesters valid continuously, no lock, reads -> grants alternate 0,1,0,1 starting with 0.
REQ-041 Requester 1 locks with MAX_BURST=4 while requester 0 is valid -> exactly 4 consecutive grants to 1, then a grant to 0.
REQ-042 Owner 0 locks, then drops req_valid for one cycle while requester 1 is valid -> IDLE, grant to 1 on the next cycle.
REQ-043 rst pulsed in the cycle after a read accept -> no rsp_valid, all bank reads return 0, first tie goes to requester 0.
REQ-044 Write 0x1234 to addr 15 by requester 0, read addr 15 by requester 1 next cycle -> rsp_rdata=0x1234.
